// File: rtl/serial_invert.sv
// Bit-serial two's-complement negator: bits pass unchanged up to and including the first 1
// of a word, and every later bit is inverted. A synchronous reset on r starts a new word.
module serial_invert (
  input  logic i,
  input  logic r,
  input  logic t_clk,
  output logic y
);

  // state      | meaning
  // -----------+------------------------------------------------
  // WAIT_ONE   | no 1 consumed yet in this word; y follows i
  // INVERT     | first 1 already passed; y = ~i until next reset
  typedef enum logic {
    WAIT_ONE = 1'b0,
    INVERT   = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   seen;

  always_ff @(posedge t_clk) begin
    if (r) begin
      state <= WAIT_ONE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_ONE: if (i) state_next = INVERT;
      INVERT:   state_next = INVERT;
      default:  state_next = WAIT_ONE;
    endcase
  end

  assign seen = (state == INVERT);

  // The bit presented in a reset cycle already belongs to the new word, so a stale seen
  // from the abandoned word must not invert it.
  assign y = i ^ (seen & ~r);

endmodule

// File: tb/tb_serial_invert.sv
// Scoreboard bench for serial_invert: expected y is pushed from a reference model as each bit
// is driven, then popped and compared when the output is sampled mid-cycle.
module tb_serial_invert;

  logic t_clk;
  logic r;
  logic i;
  logic y;

  int n_checks;
  int n_pass;

  bit    exp_q[$];
  string tag_q[$];

  bit m_seen;
  bit prev_r;
  bit prev_i;

  serial_invert dut (
    .i     (i),
    .r     (r),
    .t_clk (t_clk),
    .y     (y)
  );

  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  task automatic check_val(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // One bit slot: model latches the previous slot's inputs at the edge, the new inputs are
  // driven just after it, and y is compared at the falling edge.
  task automatic step(input bit r_v, input bit i_v, input string tag);
    bit    e;
    string t;
    @(posedge t_clk);
    if (prev_r) m_seen = 1'b0;
    else if (prev_i) m_seen = 1'b1;
    #1;
    r = r_v;
    i = i_v;
    prev_r = r_v;
    prev_i = i_v;
    e = r_v ? i_v : (i_v ^ m_seen);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge t_clk);
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, y, e);
    end
  endtask

  task automatic check_seen(input string tag);
    check_val(tag, dut.seen, m_seen);
  endtask

  task automatic run_word(input bit [3:0] w, input string tag);
    step(1'b1, 1'b0, {tag, "_rst"});
    for (int k = 0; k < 4; k++) step(1'b0, w[k], tag);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_seen   = 1'b0;
    prev_r   = 1'b1;
    prev_i   = 1'b0;
    r = 1'b1;
    i = 1'b0;

    // reset then 6 = 0,1,1,0 -> 0,1,0,1
    step(1'b1, 1'b0, "rst_y");
    step(1'b0, 1'b0, "w6_b0");
    check_seen("w6_seen_after_rst");
    step(1'b0, 1'b1, "w6_b1");
    step(1'b0, 1'b1, "w6_b2");
    step(1'b0, 1'b0, "w6_b3");
    check_val("w6_seen_set", dut.seen, 1'b1);

    // all zeros
    run_word(4'b0000, "zero");
    step(1'b0, 1'b0, "zero_b4");
    check_val("zero_seen_clear", dut.seen, 1'b0);

    // 13 = 1,0,1,1 -> 1,1,0,0
    run_word(4'b1101, "w13");

    // most negative: 0,0,0,1 -> unchanged
    run_word(4'b1000, "mostneg");

    // reset mid-word with i=1
    step(1'b1, 1'b0, "mid_rst0");
    step(1'b0, 1'b1, "mid_set");
    step(1'b1, 1'b1, "mid_rst_bit0");
    check_seen("mid_seen_before");
    step(1'b0, 1'b0, "mid_b1");
    check_val("mid_seen_cleared", dut.seen, 1'b0);
    step(1'b0, 1'b1, "mid_b2");
    step(1'b0, 1'b0, "mid_b3");

    // combinational path with seen=1, no edge between toggles
    step(1'b0, 1'b0, "comb_pre");
    #1; i = 1'b1; #1;
    check_val("comb_i1", y, 1'b0);
    i = 1'b0; #1;
    check_val("comb_i0", y, 1'b1);

    // reset priority: r=1, i=1 for two edges
    step(1'b1, 1'b1, "prio_a");
    step(1'b1, 1'b1, "prio_b");
    check_val("prio_seen_a", dut.seen, 1'b0);
    step(1'b1, 1'b1, "prio_c");
    check_val("prio_seen_b", dut.seen, 1'b0);

    // long random words with sporadic resets
    for (int n = 0; n < 200; n++) begin
      bit rr;
      rr = ($urandom_range(0, 15) == 0);
      step(rr, 1'($urandom_range(0, 1)), "rand");
      if (n % 25 == 0) check_seen("rand_seen");
    end

    if (exp_q.size() != 0) check_val("scoreboard_leftover", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
